count_sched_ctrl: RTL and testbench
===================================

Name: count_sched_ctrl

Overview:
- Shares one mod-10 up/down step counter (digit 0..9, wraps) between NREQ requesters.
- Each requester submits a job (direction plus step count) over a valid/ready handshake; a round-robin arbiter grants one job at a time.
- The FSM steps the shared counter once per cycle, then returns a one-cycle completion pulse tagged with the requester id.
- Sits between control agents and the decimal count datapath in the counter practice designs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- STEP_W, 4, width of the per-job step count; maximum job is 2^STEP_W-1 steps.
- ID_W, 1, width of the requester id; must equal max(1, clog2(NREQ)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester job request.
- req_dir  in  NREQ  per-requester direction; 1 = up (9 wraps to 0), 0 = down (0 wraps to 9).
- req_steps  in  NREQ*STEP_W  per-requester step count; requester i occupies bits [i*STEP_W +: STEP_W].
- req_ready  out  NREQ  one-hot grant/accept; the job transfers when valid & ready are high in the same cycle.
- number  out  4  current counter digit, registered.
- zero  out  1  registered; high when number==0.
- busy  out  1  high in RUN and DONE.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  id of the completed job; valid only with done_valid.
- done_number  out  4  digit at completion; valid only with done_valid.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately and is released on the next clk edge):
  - state=IDLE, number=0, zero=1, busy=0, done_valid=0, done_id=0, done_number=0, req_ready=0, rr_ptr=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Round-robin grant over req_valid, highest priority at rr_ptr and searching upward with wrap.
  - req_ready = one-hot of the granted index; req_ready is combinational from req_valid and rr_ptr, and is 0 outside IDLE or when no valid is high.
  - On handshake, capture dir, steps and id.
  - steps==0 -> go to DONE with no counter change; otherwise go to RUN with remaining=steps.
- RUN:
  - Each cycle: number <= next digit (+1/-1 with 0..9 wrap); zero <= (next digit==0); remaining--.
  - When remaining==1, the step taken that cycle is the last one; go to DONE.
- DONE (exactly one cycle):
  - done_valid=1, done_id=captured id, done_number=number.
  - rr_ptr <= (id+1) mod NREQ; next state IDLE.
- Latency: handshake on edge T -> first step visible after T+1 -> done_valid high in cycle T+steps+1.
  - steps==0 gives done_valid in cycle T+1.
  - Minimum gap between two accepts is steps+2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle; un-granted requesters hold valid; no request is starved (round-robin).
- Requester inputs are ignored outside the handshake cycle; changing req_dir/req_steps mid-job has no effect.
- Digit arithmetic: 4-bit; number never leaves 0..9.
- The counter holds its value between jobs; jobs compose (e.g. up 3 then down 5 from 0 ends at 8).
- Reset mid-job: the job is dropped with no done pulse; the counter returns to 0.

Optional Feature:
- Macro: COUNT_SCHED_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output done_aborted (1 bit, reset 0).
  - abort high in RUN: no step that cycle; go to DONE next cycle with done_aborted=1 and done_number = the partial digit.
  - abort is ignored in IDLE and DONE.
  - done_aborted=0 for normally completed jobs.
- Undefined: neither port exists; every job runs to completion.

Decomposition:
- Package count_sched_pkg:
  - state enum (IDLE, RUN, DONE).
  - DIGIT_MAX=4'd9.
  - functions digit_inc/digit_dec implementing the wrap.
- Sub-module count_rr_arb:
  - Combinational round-robin arbiter: req[NREQ] plus ptr -> one-hot grant and encoded index.
  - rr_ptr storage stays in the parent.

Test Plan:
- Reset, then requester 0 submits up, steps=3: number 1,2,3 on consecutive cycles; done_valid in cycle T+4 with done_id=0, done_number=3, zero=0 throughout.
- From 0, down, steps=1: number=9; done_number=9. Then up, steps=1: number=0, zero=1.
- Both requesters valid continuously with steps=2: grants alternate 0,1,0,1; each accept is 4 cycles after the previous one.
- steps=0 job: done_valid in cycle T+1, number unchanged. Next, up, steps=15 from 0: wraps through 9->0 and ends at 5.
- Assert rst two cycles into a 10-step job: outputs return to reset values immediately with no done pulse; the next job starts from 0.
- With COUNT_SCHED_ABORT_EN: up, steps=8, abort at the third RUN cycle -> done_aborted=1, done_number=2.

Source files
------------

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types and mod-10 digit helpers for the count scheduler
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  // Out-of-range digits fold back to 9 so the counter can never escape 0..9.
  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0 || d > DIGIT_MAX) ? DIGIT_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/count_rr_arb.sv
// rtl/count_rr_arb.sv - combinational round-robin arbiter, priority starts at ptr and wraps upward
module count_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/count_sched_ctrl.sv
// rtl/count_sched_ctrl.sv - shared mod-10 step counter scheduled among NREQ requesters
// Optional abort input / done_aborted output enabled by COUNT_SCHED_ABORT_EN.
module count_sched_ctrl
  import count_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int STEP_W = 4,
  parameter int ID_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_dir,
  input  logic [NREQ*STEP_W-1:0] req_steps,
  output logic [NREQ-1:0]        req_ready,
  output logic [3:0]             number,
  output logic                   zero,
  output logic                   busy,
  output logic                   done_valid,
  output logic [ID_W-1:0]        done_id,
`ifdef COUNT_SCHED_ABORT_EN
  output logic [3:0]             done_number,
  input  logic                   abort,
  output logic                   done_aborted
`else
  output logic [3:0]             done_number
`endif
);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cap_id;
  logic                cap_dir;
  logic [STEP_W-1:0]   remaining;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [STEP_W-1:0]   sel_steps;
  logic [3:0]          next_digit;

  count_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready  = (state == IDLE) ? grant : '0;
  assign sel_steps  = req_steps[grant_idx*STEP_W +: STEP_W];
  assign next_digit = cap_dir ? digit_inc(number) : digit_dec(number);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cap_id       <= '0;
      cap_dir      <= 1'b0;
      remaining    <= '0;
      number       <= 4'd0;
      zero         <= 1'b1;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      done_number  <= 4'd0;
`ifdef COUNT_SCHED_ABORT_EN
      done_aborted <= 1'b0;
`endif
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cap_id  <= grant_idx;
            cap_dir <= req_dir[grant_idx];
            busy    <= 1'b1;
            if (sel_steps == '0) begin
              state        <= DONE;
              done_valid   <= 1'b1;
              done_id      <= grant_idx;
              done_number  <= number;
`ifdef COUNT_SCHED_ABORT_EN
              done_aborted <= 1'b0;
`endif
            end else begin
              state     <= RUN;
              remaining <= sel_steps;
            end
          end
        end
        RUN: begin
`ifdef COUNT_SCHED_ABORT_EN
          if (abort) begin
            state        <= DONE;
            done_valid   <= 1'b1;
            done_id      <= cap_id;
            done_number  <= number;
            done_aborted <= 1'b1;
          end else
`endif
          begin
            number    <= next_digit;
            zero      <= (next_digit == 4'd0);
            remaining <= remaining - 1'b1;
            if (remaining == STEP_W'(1)) begin
              state        <= DONE;
              done_valid   <= 1'b1;
              done_id      <= cap_id;
              done_number  <= next_digit;
`ifdef COUNT_SCHED_ABORT_EN
              done_aborted <= 1'b0;
`endif
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= (cap_id == ID_W'(NREQ - 1)) ? '0 : cap_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched_ctrl.sv
// tb/tb_count_sched_ctrl.sv - randomized and directed bench against a timeline model of the scheduler
module tb_count_sched_ctrl;

  localparam int NREQ   = 2;
  localparam int STEP_W = 4;
  localparam int ID_W   = 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_dir = '0;
  logic [NREQ*STEP_W-1:0] req_steps = '0;
  logic [NREQ-1:0]        req_ready;
  logic [3:0]             number;
  logic                   zero;
  logic                   busy;
  logic                   done_valid;
  logic [ID_W-1:0]        done_id;
  logic [3:0]             done_number;
`ifdef COUNT_SCHED_ABORT_EN
  logic                   abort = 1'b0;
  logic                   done_aborted;
`endif

  count_sched_ctrl #(.NREQ(NREQ), .STEP_W(STEP_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .req_ready    (req_ready),
    .number       (number),
    .zero         (zero),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_id      (done_id),
`ifdef COUNT_SCHED_ABORT_EN
    .done_number  (done_number),
    .abort        (abort),
    .done_aborted (done_aborted)
`else
    .done_number  (done_number)
`endif
  );

  always #5 clk = ~clk;

  int vectors_applied = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int id;
    int dir;
    int steps;
    int abort_at;
  } job_t;

  job_t jobs[$];

  // Model: the active job is described by its accept edge and parameters;
  // every observable is a function of edges elapsed since that accept.
  int cyc = 0;
  bit act = 0;
  int j_start, j_s, j_dir, j_id, j_num0, j_abort;
  int m_num = 0;
  int m_ptr = 0;

  function automatic int digit_at(input int k);
    return ((j_num0 + (j_dir != 0 ? k : -k)) % 10 + 10) % 10;
  endfunction

  function automatic bit job_aborted();
    return (j_abort >= 0) && (j_abort < j_s);
  endfunction

  task automatic model_reset();
    cyc = 0; act = 0; m_num = 0; m_ptr = 0;
    jobs.delete();
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    req_valid = '0;
    #1;
    check_value("rst_number", number, 0);
    check_value("rst_zero", zero, 1);
    check_value("rst_busy", busy, 0);
    check_value("rst_done_valid", done_valid, 0);
    check_value("rst_done_id", done_id, 0);
    check_value("rst_done_number", done_number, 0);
    check_value("rst_req_ready", req_ready, 0);
`ifdef COUNT_SCHED_ABORT_EN
    check_value("rst_done_aborted", done_aborted, 0);
`endif
    @(posedge clk);
    #1;
    check_value("rst_hold_done_valid", done_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step_cycle();
    int t, taken, jend, exp_n, g;
    bit edone;
    logic [NREQ-1:0] eready;
    int head[NREQ];
    @(negedge clk);
    t = cyc - j_start;
    taken = job_aborted() ? j_abort : j_s;
    jend  = job_aborted() ? j_abort + 1 : j_s;
    if (act && t > jend) begin
      act = 0;
      m_num = digit_at(taken);
    end
    edone = act && (t == jend);
    exp_n = act ? digit_at(t < taken ? t : taken) : m_num;
    check_value("number", number, exp_n);
    check_value("zero", zero, exp_n == 0);
    check_value("busy", busy, act);
    check_value("done_valid", done_valid, edone);
    if (edone) begin
      check_value("done_id", done_id, j_id);
      check_value("done_number", done_number, exp_n);
`ifdef COUNT_SCHED_ABORT_EN
      check_value("done_aborted", done_aborted, job_aborted());
`endif
    end
    for (int i = 0; i < NREQ; i++) head[i] = -1;
    for (int k = 0; k < jobs.size(); k++)
      if (head[jobs[k].id] < 0) head[jobs[k].id] = k;
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] >= 0) begin
        req_valid[i] = 1'b1;
        req_dir[i]   = jobs[head[i]].dir[0];
        req_steps[i*STEP_W +: STEP_W] = STEP_W'(jobs[head[i]].steps);
      end else begin
        req_valid[i] = 1'b0;
        req_dir[i]   = 1'($urandom);
        req_steps[i*STEP_W +: STEP_W] = STEP_W'($urandom);
      end
    end
`ifdef COUNT_SCHED_ABORT_EN
    abort = act && (t == j_abort);
`endif
    #1;
    eready = '0;
    g = -1;
    if (!act) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) begin
          g = idx;
          eready[idx] = 1'b1;
        end
      end
    end
    check_value("req_ready", req_ready, eready);
    if (g >= 0) begin
      act     = 1;
      j_start = cyc + 1;
      j_num0  = m_num;
      j_id    = g;
      j_s     = jobs[head[g]].steps;
      j_dir   = jobs[head[g]].dir;
      j_abort = jobs[head[g]].abort_at;
      m_ptr   = (g + 1) % NREQ;
      jobs.delete(head[g]);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_jobs(input int max_cycles);
    int n;
    n = 0;
    while ((jobs.size() > 0 || act) && n < max_cycles) begin
      step_cycle();
      n++;
    end
    check_value("drain", jobs.size() + int'(act), 0);
  endtask

  task automatic push_job(input int id, input int dir, input int steps, input int abort_at);
    jobs.push_back('{id: id, dir: dir, steps: steps, abort_at: abort_at});
  endtask

  initial begin
    int n;
    apply_reset();

    push_job(0, 1, 3, -1);
    run_jobs(100);
    check_value("up3_final", number, 3);

    apply_reset();
    push_job(1, 0, 1, -1);
    push_job(1, 1, 1, -1);
    run_jobs(100);
    check_value("down_up_final", number, 0);
    check_value("down_up_zero", zero, 1);

    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_job(0, 1, 2, -1);
      push_job(1, 1, 2, -1);
    end
    run_jobs(200);
    check_value("alternate_final", number, 6);

    apply_reset();
    push_job(0, 1, 0, -1);
    push_job(0, 1, 15, -1);
    run_jobs(100);
    check_value("wrap15_final", number, 5);

    apply_reset();
    push_job(1, 1, 10, -1);
    n = 0;
    while (!(act && (cyc - j_start) == 2) && n < 50) begin
      step_cycle();
      n++;
    end
    check_value("midjob_reached", act, 1);
    apply_reset();
    push_job(0, 1, 3, -1);
    run_jobs(100);
    check_value("after_reset_final", number, 3);

`ifdef COUNT_SCHED_ABORT_EN
    apply_reset();
    push_job(0, 1, 8, 2);
    run_jobs(100);
    check_value("abort_final", number, 2);
`endif

    apply_reset();
    for (int i = 0; i < 60; i++) begin
      int ab;
      ab = -1;
`ifdef COUNT_SCHED_ABORT_EN
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 15);
`endif
      push_job($urandom_range(0, NREQ - 1), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4), ab);
    end
    run_jobs(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
